io_bridge_target: RTL and testbench

//  Parametrised slave on the external IO bridge bus (io_address/io_bus_enable/io_rw/io_acknowledge/io_irq).

---
 rtl/io_bridge_target.sv | 220 ++++++++++++++++++++++
 tb/tb_io_bridge_target.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/io_bridge_target.sv
`default_nettype none
// ============================================================================
// Module   : io_bridge_target
// Purpose  : IO-bridge bus slave exposing NUM_CH channels of output latch,
//            sampled input, IRQ mask and rising-edge capture status.
//            Optional IO_IN_SYNC_EN adds a 2-flop input synchroniser.
// Revision : 1.0  initial release
// ============================================================================
module io_bridge_target #(
  parameter int                NUM_CH      = 4,
  parameter int                ADDR_W      = 16,
  parameter int                DATA_W      = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                WAIT_STATES = 1
) (
  input  logic                     clk_clk,
  input  logic                     reset_reset,
  input  logic [ADDR_W-1:0]        io_address,
  input  logic                     io_bus_enable,
  input  logic [DATA_W/8-1:0]      io_byte_enable,
  input  logic                     io_rw,
  input  logic [DATA_W-1:0]        io_write_data,
  output logic [DATA_W-1:0]        io_read_data,
  output logic                     io_acknowledge,
  output logic                     io_irq,
  output logic [NUM_CH*DATA_W-1:0] ch_out_export,
  input  logic [NUM_CH*DATA_W-1:0] ch_in_export
);

  localparam int              BE_W     = DATA_W / 8;
  localparam int              CHB      = (NUM_CH <= 2) ? 1 : $clog2(NUM_CH);
  localparam int              HB       = CHB + 2;
  localparam logic [CHB:0]    NUM_CH_W = (CHB + 1)'(NUM_CH);
  localparam logic [3:0]      WS_LAST  = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_rw;
  logic [BE_W-1:0]     r_be;
  logic [DATA_W-1:0]   r_wdata;
  logic [3:0]          r_wait_cnt;

  // ---------------------------------------------------------------- bus FSM
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_rw       <= 1'b0;
      r_be       <= '0;
      r_wdata    <= '0;
      r_wait_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && io_bus_enable) begin
        r_addr     <= io_address;
        r_rw       <= io_rw;
        r_be       <= io_byte_enable;
        r_wdata    <= io_write_data;
        r_wait_cnt <= '0;
      end else if (r_state == ST_WAIT) begin
        r_wait_cnt <= r_wait_cnt + 4'd1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (io_bus_enable) w_state_nxt = (WAIT_STATES == 0) ? ST_ACK : ST_WAIT;
      ST_WAIT: begin
        // A master dropping the request before ack aborts with no side effect.
        if (!io_bus_enable)             w_state_nxt = ST_IDLE;
        else if (r_wait_cnt == WS_LAST) w_state_nxt = ST_ACK;
      end
      ST_ACK:  w_state_nxt = ST_HOLD;
      ST_HOLD: if (!io_bus_enable) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ----------------------------------------------------------------- decode
  logic [1:0]        w_reg;
  logic [CHB-1:0]    w_ch;
  logic              w_hit;
  logic              w_ack;
  logic              w_commit;
  logic [DATA_W-1:0] w_lane_mask;
  logic [DATA_W-1:0] w_wmask;

  assign w_reg    = r_addr[1:0];
  assign w_ch     = r_addr[HB-1:2];
  assign w_hit    = (r_addr[ADDR_W-1:HB] == BASE_ADDR[ADDR_W-1:HB]) && ({1'b0, w_ch} < NUM_CH_W);
  assign w_ack    = (r_state == ST_ACK);
  assign w_commit = w_ack && !r_rw && w_hit;
  assign w_wmask  = r_wdata & w_lane_mask;

  for (genvar i = 0; i < BE_W; i++) begin : g_lane
    assign w_lane_mask[i*8 +: 8] = {8{r_be[i]}};
  end

  // ------------------------------------------------------------- input path
  logic [NUM_CH*DATA_W-1:0] w_in_next;

`ifdef IO_IN_SYNC_EN
  localparam int PRIME_LEN = 3;
  logic [NUM_CH*DATA_W-1:0] r_sync1;
  logic [NUM_CH*DATA_W-1:0] r_sync2;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= ch_in_export;
      r_sync2 <= r_sync1;
    end
  end
  assign w_in_next = r_sync2;
`else
  localparam int PRIME_LEN = 1;
  assign w_in_next = ch_in_export;
`endif

  logic [NUM_CH*DATA_W-1:0] r_sample;
  logic [PRIME_LEN-1:0]     r_primed;
  logic [NUM_CH*DATA_W-1:0] w_edge;

  // Edge detection stays off until the sample pipeline holds real input,
  // so an input already high at reset release is not seen as an edge.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_sample <= '0;
      r_primed <= '0;
    end else begin
      r_sample <= w_in_next;
      r_primed <= PRIME_LEN'({r_primed, 1'b1});
    end
  end

  assign w_edge = r_primed[PRIME_LEN-1] ? (w_in_next & ~r_sample) : '0;

  // --------------------------------------------------------------- channels
  logic [DATA_W-1:0] w_out_arr  [NUM_CH];
  logic [DATA_W-1:0] w_in_arr   [NUM_CH];
  logic [DATA_W-1:0] w_mask_arr [NUM_CH];
  logic [DATA_W-1:0] w_stat_arr [NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [DATA_W-1:0] r_out;
    logic [DATA_W-1:0] r_mask;
    logic [DATA_W-1:0] r_stat;
    logic              w_sel;
    logic [DATA_W-1:0] w_clr;

    assign w_sel = w_commit && (w_ch == CHB'(c));
    assign w_clr = (w_sel && w_reg == 2'd3) ? w_wmask : '0;

    always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
        r_out  <= '0;
        r_mask <= '0;
        r_stat <= '0;
      end else begin
        if (w_sel && w_reg == 2'd0) r_out  <= (r_out  & ~w_lane_mask) | w_wmask;
        if (w_sel && w_reg == 2'd2) r_mask <= (r_mask & ~w_lane_mask) | w_wmask;
        // Set wins over clear when a new edge lands in the W1C cycle.
        r_stat <= (r_stat & ~w_clr) | w_edge[c*DATA_W +: DATA_W];
      end
    end

    assign ch_out_export[c*DATA_W +: DATA_W] = r_out;
    assign w_out_arr[c]  = r_out;
    assign w_in_arr[c]   = r_sample[c*DATA_W +: DATA_W];
    assign w_mask_arr[c] = r_mask;
    assign w_stat_arr[c] = r_stat;
  end

  // ------------------------------------------------------ read data and irq
  logic [DATA_W-1:0] w_rdata;
  logic              w_irq_any;
  logic              r_irq;

  always_comb begin
    w_rdata = '0;
    if (w_ack && r_rw && w_hit) begin
      case (w_reg)
        2'd0:    w_rdata = w_out_arr[w_ch];
        2'd1:    w_rdata = w_in_arr[w_ch];
        2'd2:    w_rdata = w_mask_arr[w_ch];
        default: w_rdata = w_stat_arr[w_ch];
      endcase
    end
  end

  always_comb begin
    w_irq_any = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_irq_any = w_irq_any | (|(w_stat_arr[c] & w_mask_arr[c]));
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) r_irq <= 1'b0;
    else             r_irq <= w_irq_any;
  end

  assign io_read_data   = w_rdata;
  assign io_acknowledge = w_ack;
  assign io_irq         = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_io_bridge_target.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_bridge_target
// Purpose  : Scoreboard bench for io_bridge_target (WAIT_STATES = 2).
// Revision : 1.0  initial release
// ============================================================================
module tb_io_bridge_target;

  localparam int WS = 2;

  logic        clk;
  logic        rst;
  logic [15:0] io_address;
  logic        io_bus_enable;
  logic [1:0]  io_byte_enable;
  logic        io_rw;
  logic [15:0] io_write_data;
  logic [15:0] io_read_data;
  logic        io_acknowledge;
  logic        io_irq;
  logic [63:0] ch_out_export;
  logic [63:0] ch_in_export;

  io_bridge_target #(
    .NUM_CH(4), .ADDR_W(16), .DATA_W(16), .BASE_ADDR(16'h0000), .WAIT_STATES(WS)
  ) dut (
    .clk_clk        (clk),
    .reset_reset    (rst),
    .io_address     (io_address),
    .io_bus_enable  (io_bus_enable),
    .io_byte_enable (io_byte_enable),
    .io_rw          (io_rw),
    .io_write_data  (io_write_data),
    .io_read_data   (io_read_data),
    .io_acknowledge (io_acknowledge),
    .io_irq         (io_irq),
    .ch_out_export  (ch_out_export),
    .ch_in_export   (ch_in_export)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        is_rd;
    logic [15:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   ack_seen = 0;
  logic prev_ack = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every ack pops one expected response.
  always @(negedge clk) begin
    if (io_acknowledge === 1'b1) begin
      exp_t e;
      ack_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack actual=ack expected=no_ack at cycle %0d", cyc);
      end else begin
        e = exp_q.pop_front();
        if (e.is_rd) check("read_data", 64'(io_read_data), 64'(e.data));
      end
    end
    if (prev_ack && io_acknowledge === 1'b0) check("read_data_idle", 64'(io_read_data), 64'h0);
    prev_ack = (io_acknowledge === 1'b1);
  end

  task automatic bus(input logic [15:0] addr, input logic rw, input logic [1:0] be,
                     input logic [15:0] wd, input logic [15:0] exp_rd,
                     input int hold, input logic edge_at_ack);
    int start;
    bit got;
    @(negedge clk);
    io_address     = addr;
    io_rw          = rw;
    io_byte_enable = be;
    io_write_data  = wd;
    io_bus_enable  = 1'b1;
    exp_q.push_back('{rw, exp_rd});
    start = cyc;
    got   = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (io_acknowledge === 1'b1) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout addr=%h actual=no_ack expected=ack", addr);
      if (exp_q.size() > 0) void'(exp_q.pop_back());
    end else begin
      check("ack_latency", 64'(cyc - start), 64'(1 + WS));
      if (edge_at_ack) ch_in_export[0] = 1'b1;
    end
    repeat (hold) @(negedge clk);
    io_bus_enable = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int acks_before;
    rst = 1'b1;
    io_address = '0; io_bus_enable = 1'b0; io_byte_enable = '0;
    io_rw = 1'b0; io_write_data = '0; ch_in_export = '0;
    repeat (3) @(negedge clk);
    check("rst_ack", 64'(io_acknowledge), 64'h0);
    check("rst_irq", 64'(io_irq), 64'h0);
    check("rst_rdata", 64'(io_read_data), 64'h0);
    check("rst_ch_out", ch_out_export, 64'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // byte-lane write on ch1 DATA_OUT
    bus(16'h0004, 1'b0, 2'b11, 16'h1234, 16'h0, 0, 1'b0);
    bus(16'h0004, 1'b0, 2'b01, 16'hA5C3, 16'h0, 0, 1'b0);
    check("ch1_out", ch_out_export, 64'h0000_0000_12C3_0000);
    bus(16'h0004, 1'b1, 2'b00, 16'h0, 16'h12C3, 0, 1'b0);

    // sampled input on ch2, writes to DATA_IN ignored
    ch_in_export[47:32] = 16'h00F0;
    repeat (2) @(negedge clk);
    bus(16'h0009, 1'b1, 2'b00, 16'h0, 16'h00F0, 0, 1'b0);
    bus(16'h0009, 1'b0, 2'b11, 16'h5555, 16'h0, 0, 1'b0);
    bus(16'h0009, 1'b1, 2'b00, 16'h0, 16'h00F0, 0, 1'b0);
    check("irq_masked_off", 64'(io_irq), 64'h0);

    // edge capture and irq on ch0
    bus(16'h0002, 1'b0, 2'b11, 16'h0001, 16'h0, 0, 1'b0);
    ch_in_export[0] = 1'b1;
    @(negedge clk);
    check("irq_lag", 64'(io_irq), 64'h0);
    @(negedge clk);
    check("irq_set", 64'(io_irq), 64'h1);
    bus(16'h0003, 1'b1, 2'b00, 16'h0, 16'h0001, 0, 1'b0);
    bus(16'h0003, 1'b0, 2'b11, 16'h0001, 16'h0, 0, 1'b0);
    check("irq_cleared", 64'(io_irq), 64'h0);
    bus(16'h0003, 1'b1, 2'b00, 16'h0, 16'h0000, 0, 1'b0);
    ch_in_export[0] = 1'b0;
    repeat (2) @(negedge clk);
    ch_in_export[0] = 1'b1;
    repeat (2) @(negedge clk);
    ch_in_export[0] = 1'b0;
    repeat (2) @(negedge clk);
    check("irq_reset_edge", 64'(io_irq), 64'h1);
    bus(16'h0003, 1'b0, 2'b11, 16'h0001, 16'h0, 0, 1'b1);
    check("irq_w1c_vs_edge", 64'(io_irq), 64'h1);
    bus(16'h0003, 1'b1, 2'b00, 16'h0, 16'h0001, 0, 1'b0);

    // unmapped window access
    bus(16'h0010, 1'b1, 2'b00, 16'h0, 16'h0000, 0, 1'b0);
    bus(16'h0010, 1'b0, 2'b11, 16'hFFFF, 16'h0, 0, 1'b0);
    check("unmapped_no_write", ch_out_export, 64'h0000_0000_12C3_0000);

    // abort during WAIT
    @(negedge clk);
    io_address = 16'h0000; io_rw = 1'b0; io_byte_enable = 2'b11;
    io_write_data = 16'hBEEF; io_bus_enable = 1'b1;
    @(negedge clk);
    io_bus_enable = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_no_write", ch_out_export, 64'h0000_0000_12C3_0000);
    bus(16'h0000, 1'b1, 2'b00, 16'h0, 16'h0000, 0, 1'b0);

    // held request acked once
    acks_before = ack_seen;
    bus(16'h0004, 1'b1, 2'b00, 16'h0, 16'h12C3, 10, 1'b0);
    check("hold_single_ack", 64'(ack_seen - acks_before), 64'h1);

    // reset mid-transfer
    bus(16'h0000, 1'b0, 2'b11, 16'hFFFF, 16'h0, 0, 1'b0);
    check("ch0_ffff", ch_out_export, 64'h0000_0000_12C3_FFFF);
    check("irq_before_reset", 64'(io_irq), 64'h1);
    @(negedge clk);
    io_address = 16'h0008; io_rw = 1'b0; io_byte_enable = 2'b11;
    io_write_data = 16'h7777; io_bus_enable = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    io_bus_enable = 1'b0;
    @(negedge clk);
    check("midrst_ack", 64'(io_acknowledge), 64'h0);
    check("midrst_irq", 64'(io_irq), 64'h0);
    check("midrst_rdata", 64'(io_read_data), 64'h0);
    check("midrst_ch_out", ch_out_export, 64'h0);
    rst = 1'b0;
    ch_in_export[0] = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_ch_out", ch_out_export, 64'h0);
    bus(16'h0003, 1'b1, 2'b00, 16'h0, 16'h0000, 0, 1'b0);
    bus(16'h000B, 1'b1, 2'b00, 16'h0, 16'h0000, 0, 1'b0);
    bus(16'h0009, 1'b1, 2'b00, 16'h0, 16'h00F0, 0, 1'b0);
    bus(16'h0002, 1'b1, 2'b00, 16'h0, 16'h0000, 0, 1'b0);

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
